// File: rtl/mist_video_timing_if.sv
// Raster timing bundle between the timing generator (master) and the MiST video pipeline (slave).
interface mist_video_timing_if #(
  parameter int CNT_WIDTH = 10
);
  logic [3:0]           h_offset;
  logic [3:0]           v_offset;
  logic                 ce_pix;
  logic [CNT_WIDTH-1:0] hcnt;
  logic [CNT_WIDTH-1:0] vcnt;
  logic                 HBlank;
  logic                 VBlank;
  logic                 HSync;
  logic                 VSync;
  logic                 line_start;
  logic                 frame;

  modport master (
    input  h_offset, v_offset,
    output ce_pix, hcnt, vcnt, HBlank, VBlank, HSync, VSync, line_start, frame
  );

  modport slave (
    output h_offset, v_offset,
    input  ce_pix, hcnt, vcnt, HBlank, VBlank, HSync, VSync, line_start, frame
  );
endinterface

// File: rtl/mist_video_timing.sv
// Programmable raster timing generator: pixel enable, H/V counters, blanking and offset-shifted syncs.
module mist_video_timing #(
  parameter int   CE_DIV    = 4,
  parameter int   H_ACTIVE  = 256,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 24,
  parameter int   H_BP      = 88,
  parameter int   V_ACTIVE  = 224,
  parameter int   V_FP      = 8,
  parameter int   V_SYNC    = 3,
  parameter int   V_BP      = 29,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CNT_WIDTH = 10
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  mist_video_timing_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int XW      = CNT_WIDTH + 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT    = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_ACT    = CNT_WIDTH'(V_ACTIVE);
  localparam logic [XW-1:0]        HS_BASE  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0]        VS_BASE  = XW'(V_ACTIVE + V_FP);
  localparam logic [XW-1:0]        HS_LEN   = XW'(H_SYNC);
  localparam logic [XW-1:0]        VS_LEN   = XW'(V_SYNC);

  if (CE_DIV < 1) begin : g_chk_ce
    $error("mist_video_timing: CE_DIV must be >= 1");
  end
  if (H_FP < 8 || H_BP < 8 || V_FP < 8 || V_BP < 8) begin : g_chk_porch
    $error("mist_video_timing: every porch must be >= 8");
  end
  if (H_TOTAL > (1 << CNT_WIDTH) || V_TOTAL > (1 << CNT_WIDTH)) begin : g_chk_width
    $error("mist_video_timing: H_TOTAL-1 / V_TOTAL-1 do not fit CNT_WIDTH");
  end

  logic [DIV_W-1:0]     div;
  logic [3:0]           ho;
  logic [3:0]           vo;
  logic [CNT_WIDTH-1:0] hcnt;
  logic [CNT_WIDTH-1:0] vcnt;
  logic [CNT_WIDTH-1:0] hcnt_nx;
  logic [CNT_WIDTH-1:0] vcnt_nx;
  logic                 ce_pix;
  logic                 line_start;
  logic                 hblank;
  logic                 vblank;
  logic                 hsync;
  logic                 vsync;
  logic                 frame;
  logic                 tick;
  logic                 hwrap;
  logic                 fwrap;
  logic                 hs_hit;
  logic                 vs_hit;
  logic [XW-1:0]        hs_lo;
  logic [XW-1:0]        vs_lo;
  logic [XW-1:0]        hpos;
  logic [XW-1:0]        vpos;

  // Everything registered is decoded from the next counter values so outputs line up with hcnt/vcnt.
  always_comb begin
    tick    = (div == DIV_LAST);
    hwrap   = (hcnt == H_LAST);
    fwrap   = hwrap && (vcnt == V_LAST);
    hcnt_nx = hwrap ? '0 : hcnt + CNT_WIDTH'(1);
    vcnt_nx = vcnt;
    if (fwrap) begin
      vcnt_nx = '0;
    end else if (hwrap) begin
      vcnt_nx = vcnt + CNT_WIDTH'(1);
    end
    // Porches >= 8 keep the shifted window start non-negative, so unsigned compare is safe.
    hs_lo  = HS_BASE + {{(XW-4){ho[3]}}, ho};
    vs_lo  = VS_BASE + {{(XW-4){vo[3]}}, vo};
    hpos   = {1'b0, hcnt_nx};
    vpos   = {1'b0, vcnt_nx};
    hs_hit = (hpos >= hs_lo) && (hpos < hs_lo + HS_LEN);
    vs_hit = (vpos >= vs_lo) && (vpos < vs_lo + VS_LEN);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      div        <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      ce_pix     <= 1'b0;
      line_start <= 1'b0;
      hblank     <= 1'b0;
      vblank     <= 1'b0;
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      frame      <= 1'b0;
      ho         <= '0;
      vo         <= '0;
    end else begin
      ce_pix     <= tick;
      line_start <= tick && hwrap;
      if (tick) begin
        div    <= '0;
        hcnt   <= hcnt_nx;
        vcnt   <= vcnt_nx;
        hblank <= (hcnt_nx >= H_ACT);
        hsync  <= hs_hit ? HS_POL : ~HS_POL;
        if (hwrap) begin
          vblank <= (vcnt_nx >= V_ACT);
          vsync  <= vs_hit ? VS_POL : ~VS_POL;
        end
        // Offsets only move at frame start so a frame never tears.
        if (fwrap) begin
          frame <= ~frame;
          ho    <= vid.h_offset;
          vo    <= vid.v_offset;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign vid.ce_pix     = ce_pix;
  assign vid.hcnt       = hcnt;
  assign vid.vcnt       = vcnt;
  assign vid.HBlank     = hblank;
  assign vid.VBlank     = vblank;
  assign vid.HSync      = hsync;
  assign vid.VSync      = vsync;
  assign vid.line_start = line_start;
  assign vid.frame      = frame;
endmodule

// File: tb/tb_mist_video_timing.sv
// Bench for mist_video_timing: full-size line checks, reduced-geometry frame/offset checks, random run vs model.
module tb_mist_video_timing;
  localparam int NDUT = 3;

  typedef struct packed {
    logic       ce;
    logic [9:0] h;
    logic [9:0] v;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fr;
  } obs_t;

  typedef struct {
    int   hc;
    logic hb;
    logic hs;
    logic ls;
    int   vc;
  } lvec_t;

  typedef struct {
    logic [3:0] ho;
    logic [3:0] vo;
    int         cur_hs;
    int         hs_a;
    int         hs_b;
    int         vs_a;
    int         vs_b;
  } ovec_t;

  localparam obs_t RST_LO = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam obs_t RST_HI = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  h_off = '0;
  logic [3:0]  v_off = '0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  mist_video_timing_if #(.CNT_WIDTH(10)) vid0 ();
  mist_video_timing_if #(.CNT_WIDTH(10)) vid1 ();
  mist_video_timing_if #(.CNT_WIDTH(10)) vid2 ();

  assign vid0.h_offset = h_off;
  assign vid0.v_offset = v_off;
  assign vid1.h_offset = h_off;
  assign vid1.v_offset = v_off;
  assign vid2.h_offset = h_off;
  assign vid2.v_offset = v_off;

  mist_video_timing #(
    .CE_DIV(4), .H_ACTIVE(256), .H_FP(16), .H_SYNC(24), .H_BP(88),
    .V_ACTIVE(224), .V_FP(8), .V_SYNC(3), .V_BP(29),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_WIDTH(10)
  ) dut0 (.clk_sys(clk), .reset_n(reset_n), .vid(vid0));

  mist_video_timing #(
    .CE_DIV(2), .H_ACTIVE(16), .H_FP(8), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(10), .V_FP(8), .V_SYNC(3), .V_BP(8),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_WIDTH(10)
  ) dut1 (.clk_sys(clk), .reset_n(reset_n), .vid(vid1));

  mist_video_timing #(
    .CE_DIV(1), .H_ACTIVE(16), .H_FP(8), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(10), .V_FP(8), .V_SYNC(3), .V_BP(8),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_WIDTH(10)
  ) dut2 (.clk_sys(clk), .reset_n(reset_n), .vid(vid2));

  obs_t act [NDUT];
  always_comb begin
    act[0] = {vid0.ce_pix, vid0.hcnt, vid0.vcnt, vid0.HBlank, vid0.VBlank,
              vid0.HSync, vid0.VSync, vid0.line_start, vid0.frame};
    act[1] = {vid1.ce_pix, vid1.hcnt, vid1.vcnt, vid1.HBlank, vid1.VBlank,
              vid1.HSync, vid1.VSync, vid1.line_start, vid1.frame};
    act[2] = {vid2.ce_pix, vid2.hcnt, vid2.vcnt, vid2.HBlank, vid2.VBlank,
              vid2.HSync, vid2.VSync, vid2.line_start, vid2.frame};
  end

  function automatic int g_ce(input int d); return (d == 0) ? 4 : ((d == 1) ? 2 : 1); endfunction
  function automatic int g_ha(input int d); return (d == 0) ? 256 : 16; endfunction
  function automatic int g_hf(input int d); return (d == 0) ? 16 : 8; endfunction
  function automatic int g_hs(input int d); return (d == 0) ? 24 : 4; endfunction
  function automatic int g_ht(input int d); return (d == 0) ? 384 : 36; endfunction
  function automatic int g_va(input int d); return (d == 0) ? 224 : 10; endfunction
  function automatic int g_vs(input int d); return 3; endfunction
  function automatic int g_vt(input int d); return (d == 0) ? 264 : 29; endfunction

  // Reference model: edges since reset, linear pixel position within the frame, frame count, latched offsets.
  int m_k   [NDUT];
  int m_pos [NDUT];
  int m_fr  [NDUT];
  int m_ho  [NDUT];
  int m_vo  [NDUT];

  task automatic model_edge(input logic rst_n_s, input logic [3:0] hoff, input logic [3:0] voff);
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n_s) begin
        m_k[d] = 0; m_pos[d] = 0; m_fr[d] = 0; m_ho[d] = 0; m_vo[d] = 0;
      end else begin
        m_k[d]++;
        if (m_k[d] % g_ce(d) == 0) begin
          m_pos[d] = (m_pos[d] + 1) % (g_ht(d) * g_vt(d));
          if (m_pos[d] == 0) begin
            m_fr[d]++;
            m_ho[d] = int'($signed(hoff));
            m_vo[d] = int'($signed(voff));
          end
        end
      end
    end
  endtask

  function automatic obs_t model_out(input int d);
    obs_t o;
    int   h, v, hs0, vs0;
    logic pol;
    h    = m_pos[d] % g_ht(d);
    v    = m_pos[d] / g_ht(d);
    hs0  = g_ha(d) + g_hf(d) + m_ho[d];
    vs0  = g_va(d) + 8 + m_vo[d];
    pol  = (d == 2);
    o.ce = (m_k[d] > 0) && (m_k[d] % g_ce(d) == 0);
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hb = (h >= g_ha(d));
    o.vb = (v >= g_va(d));
    o.hs = (h >= hs0 && h < hs0 + g_hs(d)) ? pol : ~pol;
    o.vs = (v >= vs0 && v < vs0 + g_vs(d)) ? pol : ~pol;
    o.ls = o.ce && (h == 0);
    o.fr = m_fr[d][0];
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("ce=%b h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ls=%b fr=%b",
                     o.ce, o.h, o.v, o.hb, o.vb, o.hs, o.vs, o.ls, o.fr);
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got {%s} exp {%s}", name, cyc, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    logic       r;
    logic [3:0] a, b;
    @(posedge clk);
    r = reset_n; a = h_off; b = v_off;
    model_edge(r, a, b);
    cyc++;
    #1;
    for (int d = 0; d < NDUT; d++) check_obs($sformatf("model%0d", d), act[d], model_out(d));
  endtask

  task automatic wait_for(input int d, input int hc, input int vc, input int limit, input string name);
    int n;
    n = 0;
    while (!(act[d].ce && int'(act[d].h) == hc && (vc < 0 || int'(act[d].v) == vc)) && n < limit) begin
      step();
      n++;
    end
    if (!(act[d].ce && int'(act[d].h) == hc && (vc < 0 || int'(act[d].v) == vc))) begin
      total++; bad++;
      $display("FAIL %s timeout after %0d cycles", name, n);
    end
  endtask

  initial begin
    lvec_t lv [9];
    ovec_t ov [4];
    int    n, t_ls, cur, hs_a, hs_b, vs_a, vs_b, vb_a, tog, lows;
    logic  fr_prev;

    lv[0] = '{255, 1'b0, 1'b1, 1'b0, 0};
    lv[1] = '{256, 1'b1, 1'b1, 1'b0, 0};
    lv[2] = '{271, 1'b1, 1'b1, 1'b0, 0};
    lv[3] = '{272, 1'b1, 1'b0, 1'b0, 0};
    lv[4] = '{295, 1'b1, 1'b0, 1'b0, 0};
    lv[5] = '{296, 1'b1, 1'b1, 1'b0, 0};
    lv[6] = '{383, 1'b1, 1'b1, 1'b0, 0};
    lv[7] = '{0,   1'b0, 1'b1, 1'b1, 1};
    lv[8] = '{1,   1'b0, 1'b1, 1'b0, 1};

    ov[0] = '{4'd3,    4'd0,    24, 27, 30, 18, 20};
    ov[1] = '{4'b1000, 4'd0,    27, 16, 19, 18, 20};
    ov[2] = '{4'd0,    4'b1000, 16, 24, 27, 10, 12};
    ov[3] = '{4'd7,    4'd7,    24, 31, 34, 25, 27};

    // Reset hold, reset values, first pixel enable and its period.
    reset_n = 1'b0;
    repeat (5) step();
    check_obs("reset0", act[0], RST_LO);
    check_obs("reset1", act[1], RST_LO);
    check_obs("reset2", act[2], RST_HI);
    reset_n = 1'b1;
    n = 0;
    while (!act[0].ce && n < 20) begin step(); n++; end
    check_int("first_ce", n, 4);
    n = 0;
    do begin step(); n++; end while (!act[0].ce && n < 20);
    check_int("ce_period", n, 4);

    // Full-size line: blanking and sync edges at fixed pixel positions.
    t_ls = 0;
    for (int i = 0; i < 9; i++) begin
      wait_for(0, lv[i].hc, -1, 2000, $sformatf("line_wait%0d", i));
      check_int($sformatf("line_vec%0d_hb_hs_ls", i),
                {29'd0, act[0].hb, act[0].hs, act[0].ls}, {29'd0, lv[i].hb, lv[i].hs, lv[i].ls});
      check_int($sformatf("line_vec%0d_vcnt", i), int'(act[0].v), lv[i].vc);
      if (i == 7) t_ls = cyc;
    end
    n = 0;
    do begin step(); n++; end while (!act[0].ls && n < 2000);
    check_int("line_start_period", cyc - t_ls, 1536);

    // Offsets changed mid-frame only take effect from the next frame.
    for (int i = 0; i < 4; i++) begin
      wait_for(1, 0, 5, 3000, $sformatf("ofs_wait%0d", i));
      h_off = ov[i].ho;
      v_off = ov[i].vo;
      cur = 1000; n = 0;
      do begin
        step(); n++;
        if (!act[1].hs && int'(act[1].h) < cur) cur = int'(act[1].h);
      end while (!(act[1].ce && act[1].h == 10'd0 && act[1].v == 10'd0) && n < 3000);
      check_int($sformatf("ofs%0d_cur_hs", i), cur, ov[i].cur_hs);
      hs_a = 1000; hs_b = -1; vs_a = 1000; vs_b = -1; vb_a = 1000; tog = 0;
      fr_prev = act[1].fr;
      for (int s = 0; s < 36 * 29 * 2; s++) begin
        step();
        if (!act[1].hs) begin
          if (int'(act[1].h) < hs_a) hs_a = int'(act[1].h);
          if (int'(act[1].h) > hs_b) hs_b = int'(act[1].h);
        end
        if (!act[1].vs) begin
          if (int'(act[1].v) < vs_a) vs_a = int'(act[1].v);
          if (int'(act[1].v) > vs_b) vs_b = int'(act[1].v);
        end
        if (act[1].vb && int'(act[1].v) < vb_a) vb_a = int'(act[1].v);
        if (act[1].fr != fr_prev) tog++;
        fr_prev = act[1].fr;
      end
      check_int($sformatf("ofs%0d_hs_first", i), hs_a, ov[i].hs_a);
      check_int($sformatf("ofs%0d_hs_last", i), hs_b, ov[i].hs_b);
      check_int($sformatf("ofs%0d_vs_first", i), vs_a, ov[i].vs_a);
      check_int($sformatf("ofs%0d_vs_last", i), vs_b, ov[i].vs_b);
      check_int($sformatf("ofs%0d_vblank_first", i), vb_a, 10);
      check_int($sformatf("ofs%0d_frame_toggles", i), tog, 1);
    end

    // One-cycle reset while both syncs are active, mid-line.
    wait_for(1, 32, 26, 3000, "midreset_wait");
    check_int("midreset_pre_syncs", {30'd0, act[1].hs, act[1].vs}, 0);
    reset_n = 1'b0;
    step();
    check_obs("midreset0", act[0], RST_LO);
    check_obs("midreset1", act[1], RST_LO);
    check_obs("midreset2", act[2], RST_HI);
    reset_n = 1'b1;
    lows = 0;
    for (int s = 0; s < 100; s++) begin
      step();
      if (!act[2].ce) lows++;
    end
    check_int("ce_div1_low_cycles", lows, 0);

    // Random offset changes and occasional resets against the model.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 299) == 0) h_off = 4'($urandom);
      if ($urandom_range(0, 499) == 0) v_off = 4'($urandom);
      reset_n = ($urandom_range(0, 4999) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
